// File: rtl/lab3_mem_line_adapter_pkg.sv
// Shared types for the line-to-word memory adapter: memory message layouts,
// message type codes and the adapter state encoding.
package lab3_mem_line_adapter_pkg;

    localparam logic [2:0] MEM_READ  = 3'd0;
    localparam logic [2:0] MEM_WRITE = 3'd1;
    localparam logic [2:0] MEM_INIT  = 3'd2;

    localparam int WORDS_PER_LINE = 4;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic [1:0] {
        ADPT_IDLE = 2'd0,
        ADPT_XFER = 2'd1,
        ADPT_RESP = 2'd2
    } adpt_state_e;

    // Single-character state tag for line traces.
    function automatic logic [7:0] adpt_trace_char(adpt_state_e s);
        case (s)
            ADPT_IDLE: return "I";
            ADPT_XFER: return "X";
            default:   return "R";
        endcase
    endfunction

endpackage

// File: rtl/lab3_mem_line_adapter_if.sv
// Bundle of the line-side (cache) and word-side (memory) handshakes.
// master = cache + memory environment, slave = the adapter.
interface lab3_mem_line_adapter_if;
    import lab3_mem_line_adapter_pkg::*;

    mem_req_16B_t  linereq_msg;
    logic          linereq_val;
    logic          linereq_rdy;

    mem_resp_16B_t lineresp_msg;
    logic          lineresp_val;
    logic          lineresp_rdy;

    mem_req_4B_t   wordreq_msg;
    logic          wordreq_val;
    logic          wordreq_rdy;

    mem_resp_4B_t  wordresp_msg;
    logic          wordresp_val;
    logic          wordresp_rdy;

    modport master (
        output linereq_msg, linereq_val,
        input  linereq_rdy,
        input  lineresp_msg, lineresp_val,
        output lineresp_rdy,
        input  wordreq_msg, wordreq_val,
        output wordreq_rdy,
        output wordresp_msg, wordresp_val,
        input  wordresp_rdy
    );

    modport slave (
        input  linereq_msg, linereq_val,
        output linereq_rdy,
        output lineresp_msg, lineresp_val,
        input  lineresp_rdy,
        output wordreq_msg, wordreq_val,
        input  wordreq_rdy,
        input  wordresp_msg, wordresp_val,
        output wordresp_rdy
    );

endinterface

// File: rtl/lab3_mem_line_adapter_dpath.sv
// Datapath: latched line request, 4x32b gather register for read data,
// and the per-word request / assembled line response muxing.
module lab3_mem_line_adapter_dpath
    import lab3_mem_line_adapter_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          line_load,
    input  mem_req_16B_t  linereq_msg,
    input  logic [1:0]    word_idx,
    input  logic          gather_en,
    input  logic [1:0]    gather_idx,
    input  logic [31:0]   gather_data,
    output mem_req_4B_t   wordreq_msg,
    output mem_resp_16B_t lineresp_msg
);

    logic [2:0]   type_reg;
    logic [7:0]   opaque_reg;
    logic [27:0]  addr_reg;
    logic [31:0]  line_word_reg [WORDS_PER_LINE];
    logic [31:0]  gather_reg    [WORDS_PER_LINE];
    logic [127:0] gathered;

    // Line address is stored without its byte offset: requests are always line aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            type_reg   <= '0;
            opaque_reg <= '0;
            addr_reg   <= '0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_word_reg[i] <= '0;
                gather_reg[i]    <= '0;
            end
        end else begin
            if (line_load) begin
                type_reg   <= linereq_msg.msg_type;
                opaque_reg <= linereq_msg.opaque;
                addr_reg   <= linereq_msg.addr[31:4];
                for (int i = 0; i < WORDS_PER_LINE; i++) begin
                    line_word_reg[i] <= linereq_msg.data[32*i +: 32];
                end
            end
            if (gather_en) begin
                gather_reg[gather_idx] <= gather_data;
            end
        end
    end

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_gather
        assign gathered[32*gi +: 32] = gather_reg[gi];
    end

    always_comb begin
        wordreq_msg          = '0;
        wordreq_msg.msg_type = (type_reg == MEM_READ) ? MEM_READ : MEM_WRITE;
        wordreq_msg.opaque   = {6'd0, word_idx};
        wordreq_msg.addr     = {addr_reg, word_idx, 2'b00};
        wordreq_msg.len      = 2'd0;
        wordreq_msg.data     = line_word_reg[word_idx];
    end

    always_comb begin
        lineresp_msg          = '0;
        lineresp_msg.msg_type = type_reg;
        lineresp_msg.opaque   = opaque_reg;
        lineresp_msg.test     = 2'd0;
        lineresp_msg.len      = 4'd0;
        lineresp_msg.data     = (type_reg == MEM_READ) ? gathered : '0;
    end

    logic unused_line_bits;
    assign unused_line_bits = ^{linereq_msg.len, linereq_msg.addr[3:0]};

endmodule

// File: rtl/lab3_mem_line_adapter.sv
// Splits each 16B line request into four pipelined 4B word requests, gathers
// the in-order word responses and returns a single 16B line response.
module lab3_mem_line_adapter
    import lab3_mem_line_adapter_pkg::*;
#(
    parameter int p_max_outstanding = 4
)
(
    input  logic                    clk,
    input  logic                    reset,
    lab3_mem_line_adapter_if.slave  bus
);

    localparam logic [2:0] MAX_OUT    = 3'(p_max_outstanding);
    localparam logic [2:0] LINE_WORDS = 3'(WORDS_PER_LINE);

    adpt_state_e state_reg, state_next;
    logic [2:0]  sent_reg, sent_next;
    logic [2:0]  recv_reg, recv_next;
    logic [2:0]  in_flight;

    logic linereq_rdy;
    logic lineresp_val;
    logic wordreq_val;
    logic wordresp_rdy;
    logic line_load;
    logic gather_en;

    assign in_flight = sent_reg - recv_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ADPT_IDLE;
            sent_reg  <= '0;
            recv_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sent_reg  <= sent_next;
            recv_reg  <= recv_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sent_next    = sent_reg;
        recv_next    = recv_reg;
        linereq_rdy  = 1'b0;
        lineresp_val = 1'b0;
        wordreq_val  = 1'b0;
        wordresp_rdy = 1'b0;
        line_load    = 1'b0;
        gather_en    = 1'b0;
        case (state_reg)
            ADPT_IDLE: begin
                linereq_rdy = 1'b1;
                if (bus.linereq_val) begin
                    line_load  = 1'b1;
                    sent_next  = '0;
                    recv_next  = '0;
                    state_next = ADPT_XFER;
                end
            end
            ADPT_XFER: begin
                // Issue throttled by the in-flight window; responses always accepted.
                wordreq_val  = (sent_reg < LINE_WORDS) && (in_flight < MAX_OUT);
                wordresp_rdy = 1'b1;
                if (wordreq_val && bus.wordreq_rdy) begin
                    sent_next = sent_reg + 3'd1;
                end
                if (bus.wordresp_val) begin
                    gather_en = 1'b1;
                    recv_next = recv_reg + 3'd1;
                    if (recv_reg == LINE_WORDS - 3'd1) begin
                        state_next = ADPT_RESP;
                    end
                end
            end
            ADPT_RESP: begin
                lineresp_val = 1'b1;
                if (bus.lineresp_rdy) begin
                    state_next = ADPT_IDLE;
                end
            end
            default: state_next = ADPT_IDLE;
        endcase
    end

    assign bus.linereq_rdy  = linereq_rdy;
    assign bus.lineresp_val = lineresp_val;
    assign bus.wordreq_val  = wordreq_val;
    assign bus.wordresp_rdy = wordresp_rdy;

    lab3_mem_line_adapter_dpath u_dpath (
        .clk          (clk),
        .reset        (reset),
        .line_load    (line_load),
        .linereq_msg  (bus.linereq_msg),
        .word_idx     (sent_reg[1:0]),
        .gather_en    (gather_en),
        .gather_idx   (recv_reg[1:0]),
        .gather_data  (bus.wordresp_msg.data),
        .wordreq_msg  (bus.wordreq_msg),
        .lineresp_msg (bus.lineresp_msg)
    );

    // Memory answers in order, so each response must carry the index of the oldest word.
    assert property (@(posedge clk) disable iff (!reset)
        (state_reg == ADPT_XFER && bus.wordresp_val) |-> (bus.wordresp_msg.opaque == {6'd0, recv_reg[1:0]}));

    logic unused_resp_bits;
    assign unused_resp_bits = ^{bus.wordresp_msg.msg_type, bus.wordresp_msg.test,
                                bus.wordresp_msg.len, bus.wordresp_msg.opaque};

endmodule
